// File: rtl/apb_pkg.sv
// Shared types and constants for the APB3 memory slave front-end.
package apb_pkg;

    typedef enum logic [1:0] {IDLE, MEM, CAPT, RESP} apb_slv_state_t;

    localparam logic APB_RD = 1'b0;
    localparam logic APB_WR = 1'b1;

    // Wait states seen by the master before o_pready.
    localparam int APB_WR_WAIT  = 1;
    localparam int APB_RD_WAIT  = 2;
    localparam int APB_ERR_WAIT = 0;

endpackage

// File: rtl/apb_mem_slave.sv
// APB3 slave that turns each transfer into one single-cycle Memory_model command.
// Optional out-of-range error response enabled by defining APB_SLVERR_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int MEM_DEPTH  = 2**ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0] i_pwdata,
    output logic [DATA_WIDTH-1:0] o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr,
    output logic                  o_mem_en,
    output logic                  o_mem_wr,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data_w,
    input  logic [DATA_WIDTH-1:0] i_mem_data_r
);

    if (MEM_DEPTH < 1) begin : g_bad_depth
        $error("apb_mem_slave: MEM_DEPTH must be positive");
    end

    apb_slv_state_t state;
    logic           setup;

    assign setup = i_psel & ~i_penable;

`ifdef APB_SLVERR_EN
    logic addr_bad;
    assign addr_bad = ({1'b0, i_paddr} >= (ADDR_WIDTH+1)'(MEM_DEPTH));
`else
    assign o_pslverr = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_prdata     <= '0;
            o_pready     <= 1'b0;
            o_mem_en     <= 1'b0;
            o_mem_wr     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_data_w <= '0;
`ifdef APB_SLVERR_EN
            o_pslverr    <= 1'b0;
`endif
        end else begin
            o_mem_en <= 1'b0;
            o_pready <= 1'b0;
`ifdef APB_SLVERR_EN
            o_pslverr <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // An access phase without a setup phase is not a transfer.
                    if (setup) begin
                        o_mem_addr   <= i_paddr;
                        o_mem_data_w <= i_pwdata;
                        o_mem_wr     <= i_pwrite;
`ifdef APB_SLVERR_EN
                        if (addr_bad) begin
                            o_pready  <= 1'b1;
                            o_pslverr <= 1'b1;
                            o_prdata  <= '0;
                            state     <= RESP;
                        end else
`endif
                        begin
                            o_mem_en <= 1'b1;
                            state    <= MEM;
                        end
                    end
                end
                MEM: begin
                    // The model samples the command at this edge, so an abandoned write still lands.
                    if (!i_psel) begin
                        state <= IDLE;
                    end else if (o_mem_wr == APB_WR) begin
                        o_pready <= 1'b1;
                        state    <= RESP;
                    end else begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    if (!i_psel) begin
                        state <= IDLE;
                    end else begin
                        o_prdata <= i_mem_data_r;
                        o_pready <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomized self-checking bench for apb_mem_slave with a behavioural memory and reference model.
module tb_apb_mem_slave;
    import apb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, pen = 1'b0, pwrite = 1'b0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata, mem_data_w, mem_rd;
    logic        pready, pslverr, mem_en, mem_wr;
    logic [15:0] mem_addr;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(pen),
        .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
        .o_prdata(prdata), .o_pready(pready), .o_pslverr(pslverr),
        .o_mem_en(mem_en), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr),
        .o_mem_data_w(mem_data_w), .i_mem_data_r(mem_rd)
    );

    // Memory_model stand-in: one-cycle write commit, one-cycle registered read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) mem[mem_addr] <= mem_data_w;
            else        mem_rd <= mem[mem_addr];
        end
    end

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    endfunction

    function automatic int ref_lat(input logic wr, input logic [15:0] a);
`ifdef APB_SLVERR_EN
        if (a >= 16'd16) return 1;
`endif
        return wr ? 2 : 3;
    endfunction

    // One APB transfer; lat=0 means o_pready never came within the budget.
    task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int en_cnt, output int en_cyc, output logic en_wr);
        rdata = '0; err = 1'b0; lat = 0; en_cnt = 0; en_cyc = 0; en_wr = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        if (mem_en) en_cnt++;
        @(posedge clk); #1;
        pen = 1'b1; pwrite = ~wr; paddr = ~a; pwdata = ~d;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_en) begin en_cnt++; en_cyc = c; en_wr = mem_wr; end
            if (pready) begin
                lat = c; rdata = prdata; err = pslverr;
                break;
            end
            @(posedge clk); #1;
        end
        $display("xfer %s addr=%h wdata=%h rdata=%h err=%0d lat=%0d en=%0d",
                 wr ? "WR" : "RD", a, d, rdata, err, lat, en_cnt);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            psel = 1'b0; pen = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({prdata, pready, pslverr, mem_en, mem_wr, mem_addr, mem_data_w} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {prdata, pready, pslverr, mem_en, mem_wr, mem_addr, mem_data_w});
        end
        @(posedge clk); #1; rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset_mid;
        logic seen;
        seen = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 16'h5; pwdata = 32'hA5A5_0005;
        @(posedge clk); #1;
        pen = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({prdata, pready, pslverr, mem_en, mem_wr, mem_addr, mem_data_w} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs got=%h want=0",
                     {prdata, pready, pslverr, mem_en, mem_wr, mem_addr, mem_data_w});
        end
        repeat (3) begin
            @(negedge clk);
            if (pready) seen = 1'b1;
        end
        total++;
        if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state, IDLE); end
        @(posedge clk); #1;
        rst_n = 1'b1; psel = 1'b0; pen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (pready || mem_en) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL reset_spurious got=%0d want=0", seen); end
        total++;
        if (mem[5] !== ref_rd(16'h5)) begin bad++; $display("FAIL reset_no_commit got=%h want=%h", mem[5], ref_rd(16'h5)); end
    endtask

    task automatic test_write;
        logic [31:0] rd; logic err, ew; int lat, ec, ecy;
        xfer(1'b1, 16'h1, 32'hDEADBEEF, rd, err, lat, ec, ecy, ew);
        ref_mem[1] = 32'hDEADBEEF;
        total++;
        if (lat !== 2) begin bad++; $display("FAIL write_latency got=%0d want=2", lat); end
        total++;
        if (ec !== 1 || ecy !== 1 || ew !== 1'b1) begin
            bad++; $display("FAIL write_mem_cmd got=en%0d@%0d wr%0d want=en1@1 wr1", ec, ecy, ew);
        end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL write_err got=%0d want=0", err); end
        @(negedge clk);
        total++;
        if (mem[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL write_commit got=%h want=deadbeef", mem[1]); end
    endtask

    task automatic test_read;
        logic [31:0] rd; logic err, ew; int lat, ec, ecy;
        idle(1);
        xfer(1'b0, 16'h1, 32'h0, rd, err, lat, ec, ecy, ew);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL read_latency got=%0d want=3", lat); end
        total++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
            bad++; $display("FAIL read_data got=%h err=%0d want=deadbeef err=0", rd, err);
        end
        total++;
        if (ec !== 1 || ecy !== 1 || ew !== 1'b0) begin
            bad++; $display("FAIL read_mem_cmd got=en%0d@%0d wr%0d want=en1@1 wr0", ec, ecy, ew);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic err, ew; int lat1, lat2, ec, ecy;
        idle(1);
        xfer(1'b1, 16'h2, 32'h12345678, rd, err, lat1, ec, ecy, ew);
        ref_mem[2] = 32'h12345678;
        xfer(1'b0, 16'h2, 32'h0, rd, err, lat2, ec, ecy, ew);
        total++;
        if (lat1 !== 2 || lat2 !== 3) begin bad++; $display("FAIL b2b_latency got=%0d/%0d want=2/3", lat1, lat2); end
        total++;
        if (rd !== 32'h12345678) begin bad++; $display("FAIL b2b_data got=%h want=12345678", rd); end
    endtask

    task automatic test_abort;
        logic [31:0] rd; logic err, ew; int lat, ec, ecy;
        logic seen;
        seen = 1'b0;
        idle(1);
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b0; pwrite = 1'b0; paddr = 16'h1;
        @(posedge clk); #1;
        psel = 1'b0; pen = 1'b0;
        @(negedge clk);
        if (pready) seen = 1'b1;
        @(negedge clk);
        if (pready) seen = 1'b1;
        total++;
        if (dut.state !== IDLE) begin bad++; $display("FAIL abort_state got=%0d want=%0d", dut.state, IDLE); end
        repeat (3) begin @(negedge clk); if (pready) seen = 1'b1; end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL abort_pready got=%0d want=0", seen); end
        xfer(1'b0, 16'h1, 32'h0, rd, err, lat, ec, ecy, ew);
        total++;
        if (rd !== ref_rd(16'h1) || lat !== 3) begin
            bad++; $display("FAIL abort_reread got=%h lat=%0d want=%h lat=3", rd, lat, ref_rd(16'h1));
        end
        // An abandoned write that reached the memory cycle still lands.
        idle(1);
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 16'h3; pwdata = 32'hCAFE_0003;
        @(posedge clk); #1;
        psel = 1'b0;
        ref_mem[3] = 32'hCAFE_0003;
        idle(2);
        xfer(1'b0, 16'h3, 32'h0, rd, err, lat, ec, ecy, ew);
        total++;
        if (rd !== 32'hCAFE_0003) begin bad++; $display("FAIL abort_write_commit got=%h want=cafe0003", rd); end
    endtask

    task automatic test_no_setup;
        logic seen;
        seen = 1'b0;
        idle(1);
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b1; pwrite = 1'b1; paddr = 16'h4; pwdata = 32'h1;
        repeat (3) begin @(negedge clk); if (mem_en || pready) seen = 1'b1; end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL no_setup_ignored got=%0d want=0", seen); end
        idle(1);
    endtask

    task automatic test_random;
        logic [31:0] rd, d; logic err, ew, wr; logic [15:0] a; int lat, ec, ecy;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 16'($urandom_range(0, 15));
            d  = $urandom;
            idle(int'($urandom_range(0, 2)));
            xfer(wr, a, d, rd, err, lat, ec, ecy, ew);
            total++;
            if (lat !== ref_lat(wr, a) || err !== 1'b0 || ec !== 1 || ecy !== 1 || ew !== wr ||
                (!wr && rd !== ref_rd(a))) begin
                bad++;
                $display("FAIL random_%0d got=lat%0d err%0d en%0d@%0d rd=%h want=lat%0d err0 en1@1 rd=%h",
                         i, lat, err, ec, ecy, rd, ref_lat(wr, a), wr ? rd : ref_rd(a));
            end
            if (wr) ref_mem[int'(a)] = d;
        end
    endtask

`ifdef APB_SLVERR_EN
    task automatic test_slverr;
        logic [31:0] rd; logic err, ew, wr; logic [15:0] a; int lat, ec, ecy;
        idle(1);
        xfer(1'b0, 16'h0010, 32'h0, rd, err, lat, ec, ecy, ew);
        total++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || ec !== 0) begin
            bad++; $display("FAIL slverr_0x10 got=lat%0d err%0d rd=%h en%0d want=lat1 err1 rd=0 en0", lat, err, rd, ec);
        end
        for (int i = 0; i < 6; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 16'($urandom_range(16, 65535));
            xfer(wr, a, $urandom, rd, err, lat, ec, ecy, ew);
            total++;
            if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || ec !== 0) begin
                bad++; $display("FAIL slverr_rand_%0d got=lat%0d err%0d rd=%h en%0d want=lat1 err1 rd=0 en0", i, lat, err, rd, ec);
            end
        end
        xfer(1'b0, 16'h1, 32'h0, rd, err, lat, ec, ecy, ew);
        total++;
        if (rd !== ref_rd(16'h1) || err !== 1'b0 || lat !== 3) begin
            bad++; $display("FAIL slverr_after got=%h err%0d lat%0d want=%h err0 lat3", rd, err, lat, ref_rd(16'h1));
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem_rd = '0;
        test_reset;
        test_write;
        test_read;
        test_reset_mid;
        test_back_to_back;
        test_abort;
        test_no_setup;
        test_random;
`ifdef APB_SLVERR_EN
        test_slverr;
`endif
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB3 slave front-end sitting directly upstream of Memory_model.
- Converts APB setup/access phases from the APB master into single-cycle memory commands on the model's i_en/i_wr/i_addr/i_data_w/o_data_r port.
- Returns read data and PREADY/PSLVERR to the master.
- One instance per slave select line; decoding of SEL_WIDTH selects happens upstream, in the master/decoder.

Parameters:
- DATA_WIDTH, `DATA_WIDTH from parameters.vh: width of PWDATA, PRDATA and memory data.
- ADDR_WIDTH, `ADDR_WIDTH from parameters.vh: width of PADDR and memory address. Addresses are word addresses, passed through 1:1.
- MEM_DEPTH, 2**ADDR_WIDTH: number of implemented words. Only used with APB_SLVERR_EN.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_psel  in  1  APB select for this slave.
- i_penable  in  1  APB enable (access phase).
- i_pwrite  in  1  1=write, 0=read.
- i_paddr  in  ADDR_WIDTH  APB address.
- i_pwdata  in  DATA_WIDTH  APB write data.
- o_prdata  out  DATA_WIDTH  APB read data; valid while o_pready=1 on a read.
- o_pready  out  1  transfer complete.
- o_pslverr  out  1  transfer error; valid only with o_pready.
- o_mem_en  out  1  to Memory_model i_en.
- o_mem_wr  out  1  to Memory_model i_wr.
- o_mem_addr  out  ADDR_WIDTH  to Memory_model i_addr.
- o_mem_data_w  out  DATA_WIDTH  to Memory_model i_data_w.
- i_mem_data_r  in  DATA_WIDTH  from Memory_model o_data_r. Valid one cycle after the edge that samples en=1, wr=0.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; all outputs 0, including o_prdata, o_mem_addr and o_mem_data_w. Reset asserted mid-transfer aborts it immediately. No o_pready is ever issued for the aborted transfer.
- All outputs are registered. FSM states: IDLE, MEM, CAPT, RESP.
- IDLE:
  - Setup phase detected (i_psel=1, i_penable=0): register o_mem_addr=i_paddr, o_mem_data_w=i_pwdata, o_mem_wr=i_pwrite, o_mem_en=1; go to MEM.
  - i_penable=1 without a preceding setup: ignored; no memory access, o_pready stays 0.
- MEM (first access cycle):
  - Memory command is visible to the model for exactly this cycle; o_mem_en=0 on leaving.
  - Next state: CAPT for a read, RESP for a write. The write commits at the edge leaving MEM.
- CAPT (reads only): i_mem_data_r is valid; latch it into o_prdata; go to RESP.
- RESP: o_pready=1 for exactly one cycle, o_pslverr=0; then IDLE with o_pready=0. o_prdata holds its value until the next read capture.
- Latency, counted in access-phase cycles including the completion cycle:
  - write: 2 (one wait state);
  - read: 3 (two wait states).
- Back-to-back transfers: a setup phase in the cycle after RESP is accepted normally. The minimum period is 3 cycles per write and 4 per read.
- i_psel dropping in MEM or CAPT:
  - FSM returns to IDLE at the next edge with no o_pready pulse.
  - A write already in MEM still commits.
- i_pwrite, i_paddr and i_pwdata are sampled only in the setup cycle; later changes are ignored.
- o_mem_addr, o_mem_data_w and o_mem_wr hold their values between transfers. The model must only act on o_mem_en.

Optional Feature:
- APB_SLVERR_EN defined:
  - In IDLE, a setup phase with i_paddr >= MEM_DEPTH leaves o_mem_en=0 and goes directly to RESP.
  - RESP then drives o_pready=1, o_pslverr=1 and o_prdata=0.
  - Error latency is 1 access cycle; the memory is untouched.
- APB_SLVERR_EN undefined: o_pslverr is tied to 0, MEM_DEPTH is unused, and every address is forwarded.

Decomposition:
- apb_pkg holds:
  - typedef enum logic [1:0] {IDLE, MEM, CAPT, RESP} apb_slv_state_t;
  - localparam APB_RD=1'b0 and APB_WR=1'b1;
  - read/write wait-state count constants, for bench checks.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles mid-run -> all outputs 0 and FSM in IDLE. Release -> no spurious o_mem_en.
- Write: setup addr=16'h0001, data=32'hDEADBEEF, write=1 -> o_mem_en=1 and o_mem_wr=1 for one cycle in the first access cycle. o_pready=1 in the 2nd access cycle. The model holds DEADBEEF at address 1.
- Read: read addr=16'h0001 after the write above -> o_pready in the 3rd access cycle with o_prdata=32'hDEADBEEF, o_pslverr=0.
- Back-to-back: write 0x2=32'h12345678, then immediately read 0x2 (setup in the cycle after RESP) -> both complete with correct latencies and the read returns 12345678.
- Abort: deassert i_psel in MEM of a read of 0x1 -> no o_pready, FSM in IDLE the next cycle. A following read of 0x1 works normally.
- APB_SLVERR_EN with MEM_DEPTH=16: read 16'h0010 -> o_pready and o_pslverr=1 in the 1st access cycle, o_prdata=0, o_mem_en never asserted.
